// File: rtl/bus_pkg.sv
// bus_pkg: shared types for the two-master bus (scheduler, decoder, mux).
//   state_t  : scheduler FSM states (IDLE / GRANT / TURN)
//   master_t : master identity; the value doubles as the bit index of the
//              per-master vectors (parked, resume priority, eligibility).
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   typedef enum logic {
      M1 = 1'b0,
      M2 = 1'b1
   } master_t;

   function automatic master_t other(input master_t m);
      return (m == M1) ? M2 : M1;
   endfunction

endpackage

// File: rtl/tenure_counter.sv
// tenure_counter: per-tenure transfer counter and watchdog.
//   clk, rst_n  : clock, async active-low reset
//   clear       : grant is starting; both counters restart from zero
//   run         : bus is in a granted tenure
//   done        : xfer_done pulse from the slave
//   hold_full   : hold count has saturated at HOLD_MAX-1
//   wd_expired  : watchdog has reached TIMEOUT_CYC-1
module tenure_counter #(
   parameter int HOLD_MAX    = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic run,
   input  logic done,
   output logic hold_full,
   output logic wd_expired
);

   localparam int HW = $clog2(HOLD_MAX + 1);
   localparam int WW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [HW-1:0] HOLD_TOP = HW'(HOLD_MAX - 1);
   localparam logic [WW-1:0] WD_TOP   = WW'(TIMEOUT_CYC - 1);

   logic [HW-1:0] hold_cnt;
   logic [WW-1:0] wd_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
         wd_cnt   <= '0;
      end else if (clear) begin
         hold_cnt <= '0;
         wd_cnt   <= '0;
      end else if (run) begin
         if (done) begin
            // A completed transfer proves the slave is alive.
            wd_cnt <= '0;
            if (hold_cnt != HOLD_TOP) hold_cnt <= hold_cnt + 1'b1;
         end else if (wd_cnt != WD_TOP) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
      end
   end

   assign hold_full  = (hold_cnt == HOLD_TOP);
   assign wd_expired = (wd_cnt == WD_TOP);

endmodule

// File: rtl/bus_scheduler.sv
// bus_scheduler: two-master bus arbiter with hold-limit preemption,
// split/resume support and a per-tenure watchdog.
//   clk, rst_n           : clock, async active-low reset
//   m1_req, m2_req       : level requests, held for the whole tenure
//   xfer_done            : one-cycle transfer-complete pulse
//   split                : slave splits the current owner's transaction
//   split_done[1:0]      : resume master 1 (bit0) / master 2 (bit1)
//   m1_grant, m2_grant   : grants, decoded from registered state only
//   m_select             : 0 only while master 2 holds the bus
//   bus_busy             : either grant high
//   parked[1:0]          : per-master split-parked flags
//   timeout              : one-cycle pulse when the watchdog ends a tenure
module bus_scheduler
   import bus_pkg::*;
#(
   parameter int HOLD_MAX    = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       m1_req,
   input  logic       m2_req,
   input  logic       xfer_done,
   input  logic       split,
   input  logic [1:0] split_done,
   output logic       m1_grant,
   output logic       m2_grant,
   output logic       m_select,
   output logic       bus_busy,
   output logic [1:0] parked,
   output logic       timeout
);

   state_t     state, state_nx;
   master_t    owner, owner_nx;
   master_t    target, target_nx;
   master_t    last_owner, last_nx;
   logic [1:0] resume, resume_nx;
   logic [1:0] parked_nx;
   logic       timeout_nx;
   logic       grant_start;
   logic       split_set;
   logic       hold_full, wd_expired;
   logic [1:0] elig;
   logic       owner_req;
   master_t    oth, pick;

   assign elig      = {m2_req & ~parked[1], m1_req & ~parked[0]};
   assign owner_req = (owner == M1) ? m1_req : m2_req;
   assign oth       = other(owner);

   tenure_counter #(
      .HOLD_MAX    (HOLD_MAX),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_tenure (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (grant_start),
      .run        (state == GRANT),
      .done       (xfer_done),
      .hold_full  (hold_full),
      .wd_expired (wd_expired)
   );

   // State register, with the bookkeeping that moves alongside it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= M1;
         target     <= M1;
         last_owner <= M2;   // master 1 wins the first tie
         parked     <= 2'b00;
         resume     <= 2'b00;
         timeout    <= 1'b0;
      end else begin
         state      <= state_nx;
         owner      <= owner_nx;
         target     <= target_nx;
         last_owner <= last_nx;
         parked     <= parked_nx;
         resume     <= resume_nx;
         timeout    <= timeout_nx;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx    = state;
      owner_nx    = owner;
      target_nx   = target;
      last_nx     = last_owner;
      timeout_nx  = 1'b0;
      grant_start = 1'b0;
      split_set   = 1'b0;
      pick        = M1;

      unique case (state)
         IDLE: begin
            if (elig == 2'b11) begin
               if (resume == 2'b01)      pick = M1;
               else if (resume == 2'b10) pick = M2;
               else                      pick = other(last_owner);
            end else begin
               pick = elig[1] ? M2 : M1;
            end
            if (|elig) begin
               state_nx    = GRANT;
               owner_nx    = pick;
               grant_start = 1'b1;
            end
         end
         GRANT: begin
            // Priority: split, owner release, watchdog, hold-limit preemption.
            if (split || !owner_req) begin
               split_set = split;
               last_nx   = owner;
               target_nx = oth;
               state_nx  = elig[oth] ? TURN : IDLE;
            end else if (wd_expired && !xfer_done) begin
               timeout_nx = 1'b1;
               last_nx    = owner;
               state_nx   = IDLE;
            end else if (xfer_done && hold_full && elig[oth]) begin
               last_nx   = owner;
               target_nx = oth;
               state_nx  = TURN;
            end
         end
         TURN: begin
            if (elig[target]) begin
               state_nx    = GRANT;
               owner_nx    = target;
               grant_start = 1'b1;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Park / resume flags. A split_done for a master that is not parked is
   // dropped; the resume bit is consumed by that master's next grant.
   always_comb begin
      parked_nx = parked;
      resume_nx = resume;
      for (int i = 0; i < 2; i++) begin
         if (split_done[i] && parked[i]) begin
            parked_nx[i] = 1'b0;
            resume_nx[i] = 1'b1;
         end
      end
      if (split_set)   parked_nx[owner]    = 1'b1;
      if (grant_start) resume_nx[owner_nx] = 1'b0;
   end

   // Outputs, decoded from registered state only.
   always_comb begin
      m1_grant = (state == GRANT) && (owner == M1);
      m2_grant = (state == GRANT) && (owner == M2);
      m_select = ~m2_grant;
      bus_busy = m1_grant | m2_grant;
   end

endmodule

// File: tb/tb_bus_scheduler.sv
module tb_bus_scheduler;

   localparam int HM = 4;
   localparam int TO = 64;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       m1_req = 1'b0, m2_req = 1'b0, xfer_done = 1'b0, split = 1'b0;
   logic [1:0] split_done = 2'b00;
   logic       m1_grant, m2_grant, m_select, bus_busy, timeout;
   logic [1:0] parked;

   bus_scheduler #(.HOLD_MAX(HM), .TIMEOUT_CYC(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .m1_req     (m1_req),
      .m2_req     (m2_req),
      .xfer_done  (xfer_done),
      .split      (split),
      .split_done (split_done),
      .m1_grant   (m1_grant),
      .m2_grant   (m2_grant),
      .m_select   (m_select),
      .bus_busy   (bus_busy),
      .parked     (parked),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Reference model: who holds the bus, which master a handover gap is
   // heading to, and per-tenure tallies of transfers and silent cycles.
   int own;       // 0 = nobody, else master number 1/2
   int turn_to;   // nonzero: one-cycle handover gap toward this master
   int last;      // master whose tenure ended most recently
   int n_done;    // completed transfers this tenure (saturating)
   int n_idle;    // granted cycles since grant start / last transfer
   bit pk[1:2];
   bit pr[1:2];
   bit to_q;

   task automatic model_reset();
      own = 0; turn_to = 0; last = 2; n_done = 0; n_idle = 0;
      pk[1] = 0; pk[2] = 0; pr[1] = 0; pr[2] = 0; to_q = 0;
   endtask

   function automatic bit el(int m, bit r1, bit r2);
      return ((m == 1) ? r1 : r2) && !pk[m];
   endfunction

   task automatic model_step(input bit r1, input bit r2, input bit xd, input bit sp,
                             input bit [1:0] sd);
      bit npk[1:2];
      bit npr[1:2];
      bit rq[1:2];
      int start_m = 0;
      int oth;
      rq[1] = r1; rq[2] = r2;
      npk = pk; npr = pr;
      for (int m = 1; m <= 2; m++)
         if (sd[m-1] && pk[m]) begin npk[m] = 0; npr[m] = 1; end
      to_q = 0;
      if (own != 0) begin
         oth = 3 - own;
         if (sp || !rq[own]) begin
            if (sp) npk[own] = 1;
            last = own;
            turn_to = el(oth, r1, r2) ? oth : 0;
            own = 0;
         end else if (n_idle == TO - 1 && !xd) begin
            to_q = 1; last = own; own = 0;
         end else if (xd && n_done == HM - 1 && el(oth, r1, r2)) begin
            last = own; turn_to = oth; own = 0;
         end else if (xd) begin
            n_idle = 0;
            if (n_done < HM - 1) n_done++;
         end else begin
            n_idle++;
         end
      end else if (turn_to != 0) begin
         if (el(turn_to, r1, r2)) start_m = turn_to;
         turn_to = 0;
      end else begin
         if (el(1, r1, r2) && el(2, r1, r2))
            start_m = (pr[1] && !pr[2]) ? 1 : (pr[2] && !pr[1]) ? 2 : 3 - last;
         else if (el(1, r1, r2)) start_m = 1;
         else if (el(2, r1, r2)) start_m = 2;
      end
      if (start_m != 0) begin
         own = start_m; n_done = 0; n_idle = 0; npr[start_m] = 0;
      end
      pk = npk; pr = npr;
   endtask

   task automatic cmp();
      chk("m1_grant", 32'(m1_grant), 32'(own == 1));
      chk("m2_grant", 32'(m2_grant), 32'(own == 2));
      chk("m_select", 32'(m_select), 32'(own != 2));
      chk("bus_busy", 32'(bus_busy), 32'(own != 0));
      chk("parked",   32'(parked),   32'({pk[2], pk[1]}));
      chk("timeout",  32'(timeout),  32'(to_q));
      chk("excl",     32'(m1_grant & m2_grant), 32'd0);
   endtask

   // Called at a falling edge: check the current cycle, apply new inputs,
   // advance the model across the coming rising edge.
   task automatic drive(input bit a, input bit b, input bit xd, input bit sp,
                        input bit [1:0] sd);
      cmp();
      m1_req = a; m2_req = b; xfer_done = xd; split = sp; split_done = sd;
      model_step(a, b, xd, sp, sd);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      bit r1, r2;
      int mode;
      model_reset();
      @(negedge clk);
      cmp();
      chk("rst_m_select", 32'(m_select), 32'd1);
      rst_n = 1'b1;

      // Tie at start goes to master 1; release hands over through TURN.
      drive(1, 1, 0, 0, 2'b00);
      chk("s1_m1", 32'(m1_grant), 32'd1);
      drive(0, 1, 0, 0, 2'b00);
      chk("s1_turn", 32'(bus_busy), 32'd0);
      drive(0, 1, 0, 0, 2'b00);
      chk("s1_m2", 32'(m2_grant), 32'd1);
      chk("s1_msel", 32'(m_select), 32'd0);

      // Hold limit: fourth transfer hands the bus over.
      drive(0, 0, 0, 0, 2'b00);
      drive(1, 1, 0, 0, 2'b00);
      repeat (3) drive(1, 1, 1, 0, 2'b00);
      chk("s2_hold", 32'(m1_grant), 32'd1);
      drive(1, 1, 1, 0, 2'b00);
      chk("s2_pre", 32'(bus_busy), 32'd0);
      drive(1, 1, 0, 0, 2'b00);
      chk("s2_m2", 32'(m2_grant), 32'd1);

      // Split parks master 1; resume gives it the next tie.
      drive(1, 0, 0, 0, 2'b00);
      drive(1, 1, 0, 0, 2'b00);
      chk("s3_m1", 32'(m1_grant), 32'd1);
      drive(1, 1, 0, 1, 2'b00);
      chk("s3_park", 32'(parked), 32'd1);
      drive(1, 1, 0, 0, 2'b00);
      chk("s3_m2", 32'(m2_grant), 32'd1);
      drive(1, 1, 0, 0, 2'b01);
      chk("s3_unpark", 32'(parked), 32'd0);
      drive(0, 0, 0, 0, 2'b00);
      drive(1, 1, 0, 0, 2'b00);
      chk("s3_tie", 32'(m1_grant), 32'd1);

      // Watchdog on master 2.
      drive(0, 1, 0, 0, 2'b00);
      drive(0, 1, 0, 0, 2'b00);
      repeat (TO - 1) drive(0, 1, 0, 0, 2'b00);
      chk("s4_alive", 32'(m2_grant), 32'd1);
      chk("s4_noto", 32'(timeout), 32'd0);
      drive(0, 1, 0, 0, 2'b00);
      chk("s4_to", 32'(timeout), 32'd1);
      chk("s4_drop", 32'(bus_busy), 32'd0);
      drive(0, 1, 0, 0, 2'b00);
      chk("s4_pulse", 32'(timeout), 32'd0);
      chk("s4_regrant", 32'(m2_grant), 32'd1);

      // Asynchronous reset mid-tenure.
      #2 rst_n = 1'b0;
      #1;
      chk("ar_m2", 32'(m2_grant), 32'd0);
      chk("ar_busy", 32'(bus_busy), 32'd0);
      chk("ar_msel", 32'(m_select), 32'd1);
      chk("ar_park", 32'(parked), 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Split coinciding with the preempting transfer.
      drive(1, 1, 0, 0, 2'b00);
      repeat (3) drive(1, 1, 1, 0, 2'b00);
      drive(1, 1, 1, 1, 2'b00);
      chk("s5_park", 32'(parked), 32'd1);
      chk("s5_turn", 32'(bus_busy), 32'd0);
      drive(1, 1, 0, 0, 2'b00);
      chk("s5_m2", 32'(m2_grant), 32'd1);
      drive(1, 1, 0, 0, 2'b01);

      // Randomized traffic, alternating busy and quiet phases.
      r1 = 1; r2 = 1;
      for (int c = 0; c < 4000; c++) begin
         mode = (c / 200) % 2;
         if (mode == 0) begin
            if ($urandom_range(5) == 0) r1 = ~r1;
            if ($urandom_range(5) == 0) r2 = ~r2;
            drive(r1, r2, $urandom_range(2) == 0, $urandom_range(29) == 0,
                  {$urandom_range(7) == 0, $urandom_range(7) == 0});
         end else begin
            if ($urandom_range(119) == 0) r1 = ~r1;
            if ($urandom_range(119) == 0) r2 = ~r2;
            drive(r1, r2, 1'b0, $urandom_range(199) == 0,
                  {$urandom_range(49) == 0, $urandom_range(49) == 0});
         end
      end
      cmp();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
